// File: rtl/zmips_mem_arbiter.sv
// Arbitrates the single external memory bus between instruction fetch and data access.
// Data has priority, fetch gets a starvation guard, and a stalled bus is aborted with bus_err.
module zmips_mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  localparam int unsigned STREAK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam int unsigned WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam bit                  TO_EN      = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic [WAIT_W-1:0]   wait_cnt;

  logic in_xfer;
  logic timed_out;
  logic done;

  // Word alignment makes the low address bits irrelevant.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  // Completion, abort and response steering for the transfer in flight.
  always_comb begin
    in_xfer   = (state != IDLE);
    timed_out = TO_EN && in_xfer && !mem_ack && (wait_cnt == WAIT_LAST);
    done      = in_xfer && (mem_ack || timed_out);
    if_ack    = done && (state == I_XFER);
    d_ack     = done && (state == D_XFER);
    bus_err   = timed_out;
    if_rdata  = (if_ack && mem_ack) ? mem_rdata : 32'h0;
    d_rdata   = (d_ack && mem_ack && !mem_we) ? mem_rdata : 32'h0;
    if_stall  = rst && if_req && !if_ack;
    d_stall   = rst && d_req && !d_ack;
  end

  // Grant decision, bus register load and transfer bookkeeping; state moves on the falling edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      streak    <= '0;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (if_req && (!d_req || streak == STREAK_MAX)) begin
            state     <= I_XFER;
            streak    <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {if_addr[31:2], 2'b00};
            mem_wdata <= 32'h0;
          end else if (d_req) begin
            state     <= D_XFER;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= {d_addr[31:2], 2'b00};
            mem_wdata <= d_wdata;
            // Only data wins taken while fetch waits count toward starvation.
            if (!if_req) begin
              streak <= '0;
            end else if (streak != STREAK_MAX) begin
              streak <= streak + STREAK_W'(1);
            end
          end
        end
        I_XFER, D_XFER: begin
          if (done) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zmips_mem_arbiter.sv
// Self-checking bench for zmips_mem_arbiter: directed vector table, corner sequences and
// a randomized run against a transaction-level reference model.
module tb_zmips_mem_arbiter;

  localparam int unsigned MAXS = 4;
  localparam int unsigned TOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, if_stall, d_ack, d_stall, mem_req, mem_we, bus_err;

  int n_checks = 0;
  int n_errors = 0;

  zmips_mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic ireq; logic [31:0] iaddr;
    logic dreq; logic dwe; logic [31:0] daddr; logic [31:0] dwdata;
    logic mack; logic [31:0] mrdata;
    logic e_mreq; logic e_mwe; logic [31:0] e_maddr; logic [31:0] e_mwdata;
    logic e_iack; logic [31:0] e_irdata; logic e_dack; logic [31:0] e_drdata;
    logic e_istall; logic e_dstall; logic e_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  // Reference model state: one outstanding bus transaction, owner, and data wins while fetch waits.
  logic        m_busy, m_we, m_owner_d;
  int          m_cyc, m_streak;
  logic [31:0] m_addr, m_wdata;
  logic        i_pend, d_pend;
  logic        done_e, e_iack, e_dack, e_err;
  logic [31:0] e_ird, e_drd;

  vec_t vecs [8];
  int   grants [$];
  int   n, nd;
  logic seen;

  initial begin
    // zero-wait fetch, then contested store followed by fetch with stray acks in idle
    vecs[0] = '{1'b1, 32'h106, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h106, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h12345678,
                1'b1, 1'b0, 32'h104, 32'h0, 1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h200, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h200, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 32'hCAFEF00D,
                1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h55555555,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0BADF00D,
                1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h0BADF00D, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77777777,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};

    // Reset state with every input active
    rst = 0; if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 1; d_addr = 32'h20;
    d_wdata = 32'h1; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    chk("rst mem_req", mem_req, 0);     chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);   chk("rst mem_wdata", mem_wdata, 0);
    chk("rst if_ack", if_ack, 0);       chk("rst d_ack", d_ack, 0);
    chk("rst if_stall", if_stall, 0);   chk("rst d_stall", d_stall, 0);
    chk("rst bus_err", bus_err, 0);     chk("rst if_rdata", if_rdata, 0);
    chk("rst d_rdata", d_rdata, 0);
    drive_idle();
    rst = 1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if_req = vecs[i].ireq; if_addr = vecs[i].iaddr; d_req = vecs[i].dreq; d_we = vecs[i].dwe;
      d_addr = vecs[i].daddr; d_wdata = vecs[i].dwdata; mem_ack = vecs[i].mack;
      mem_rdata = vecs[i].mrdata;
      @(posedge clk);
      chk($sformatf("row%0d mem_req", i), mem_req, vecs[i].e_mreq);
      chk($sformatf("row%0d mem_we", i), mem_we, vecs[i].e_mwe);
      if (vecs[i].e_mreq) chk($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
      if (vecs[i].e_mreq && vecs[i].e_mwe)
        chk($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
      chk($sformatf("row%0d if_ack", i), if_ack, vecs[i].e_iack);
      chk($sformatf("row%0d if_rdata", i), if_rdata, vecs[i].e_irdata);
      chk($sformatf("row%0d d_ack", i), d_ack, vecs[i].e_dack);
      chk($sformatf("row%0d d_rdata", i), d_rdata, vecs[i].e_drdata);
      chk($sformatf("row%0d if_stall", i), if_stall, vecs[i].e_istall);
      chk($sformatf("row%0d d_stall", i), d_stall, vecs[i].e_dstall);
      chk($sformatf("row%0d bus_err", i), bus_err, vecs[i].e_err);
    end

    // Starvation guard: both requesters saturate a zero-wait bus
    for (int c = 0; c < 100 && grants.size() < 15; c++) begin
      @(negedge clk); #1;
      if_req = 1; if_addr = 32'h300 + 32'(c * 4); d_req = 1; d_we = 0; d_addr = 32'h400;
      mem_ack = 1; mem_rdata = 32'(c);
      @(posedge clk);
      if (d_ack) grants.push_back(1);
      if (if_ack) grants.push_back(0);
    end
    chk("t3 grant count", 32'(grants.size()), 15);
    for (int k = 0; k < grants.size(); k++)
      chk($sformatf("t3 grant%0d is_data", k), 32'(grants[k]), (k % 5 == 4) ? 0 : 1);

    // Timeout on a silent bus, then a stray late ack
    n = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk); #1;
      if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h80; mem_ack = 0; mem_rdata = 32'hFFFFFFFF;
      @(posedge clk);
      if (mem_req) n++;
      if (d_ack) begin
        seen = 1;
        chk("t4 bus_err", bus_err, 1);
        chk("t4 d_rdata", d_rdata, 0);
      end
    end
    chk("t4 ack seen", seen, 1);
    chk("t4 xfer cycles", 32'(n), TOUT);
    @(negedge clk); #1;
    d_req = 0; mem_ack = 1;
    @(posedge clk);
    chk("t4 stray d_ack", d_ack, 0); chk("t4 stray bus_err", bus_err, 0);
    chk("t4 idle mem_req", mem_req, 0);

    // Three wait states
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      d_req = 1; d_we = 0; d_addr = 32'h20000047; mem_ack = (c == 4); mem_rdata = 32'h600DCAFE;
      @(posedge clk);
      chk($sformatf("t5 c%0d mem_req", c), mem_req, (c > 0) ? 1 : 0);
      if (c > 0) chk($sformatf("t5 c%0d mem_addr", c), mem_addr, 32'h20000044);
      chk($sformatf("t5 c%0d d_stall", c), d_stall, (c < 4) ? 1 : 0);
      chk($sformatf("t5 c%0d d_ack", c), d_ack, (c == 4) ? 1 : 0);
      if (c == 4) chk("t5 d_rdata", d_rdata, 32'h600DCAFE);
    end
    @(negedge clk); #1;
    d_req = 0; mem_ack = 0;
    @(posedge clk);
    chk("t5 after d_ack", d_ack, 0);

    // Reset during a data transfer taken at full streak
    nd = 0;
    for (int c = 0; c < 40 && nd < 3; c++) begin
      @(negedge clk); #1;
      if_req = 1; if_addr = 32'h500; d_req = 1; d_we = 0; d_addr = 32'h300; mem_ack = 1;
      @(posedge clk);
      if (d_ack) nd++;
      if (if_ack) nd = 100;
    end
    chk("t6 setup data acks", 32'(nd), 3);
    @(negedge clk); #1; mem_ack = 0;
    @(posedge clk);
    chk("t6 bubble mem_req", mem_req, 0);
    @(negedge clk); #1;
    @(posedge clk);
    chk("t6 d granted", mem_req, 1); chk("t6 d addr", mem_addr, 32'h300);
    #2 rst = 0; mem_ack = 1;
    #1;
    chk("t6 rst mem_req", mem_req, 0); chk("t6 rst d_ack", d_ack, 0);
    chk("t6 rst if_ack", if_ack, 0);   chk("t6 rst d_stall", d_stall, 0);
    @(posedge clk); rst = 1;
    @(negedge clk); #1;
    @(posedge clk);
    chk("t6 regrant d_ack", d_ack, 1); chk("t6 regrant if_ack", if_ack, 0);
    chk("t6 regrant addr", mem_addr, 32'h300);

    // Randomized run against the transaction model
    @(negedge clk); #1;
    drive_idle();
    rst = 0;
    @(posedge clk); rst = 1;
    m_busy = 0; m_streak = 0; m_cyc = 0; m_owner_d = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    i_pend = 0; d_pend = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk); #1;
      if (!i_pend && $urandom_range(2) == 0) begin
        i_pend = 1; if_addr = 32'h10000000 | ($urandom & 32'hFFFF);
      end
      if (!d_pend && $urandom_range(2) == 0) begin
        d_pend = 1; d_we = 1'($urandom_range(1));
        d_addr = 32'h20000000 | ($urandom & 32'hFFFF); d_wdata = $urandom;
      end
      if_req = i_pend; d_req = d_pend;
      mem_ack = ($urandom_range(3) == 0); mem_rdata = $urandom;
      @(posedge clk);
      done_e = m_busy && (mem_ack || m_cyc == TOUT);
      e_iack = done_e && !m_owner_d;
      e_dack = done_e && m_owner_d;
      e_err  = done_e && !mem_ack;
      e_ird  = (e_iack && mem_ack) ? mem_rdata : 32'h0;
      e_drd  = (e_dack && mem_ack && !m_we) ? mem_rdata : 32'h0;
      chk("rnd mem_req", mem_req, m_busy);
      if (m_busy) begin
        chk("rnd mem_addr", mem_addr, m_addr);
        chk("rnd mem_we", mem_we, m_we);
        if (m_we) chk("rnd mem_wdata", mem_wdata, m_wdata);
      end
      chk("rnd if_ack", if_ack, e_iack);     chk("rnd d_ack", d_ack, e_dack);
      chk("rnd bus_err", bus_err, e_err);
      chk("rnd if_rdata", if_rdata, e_ird);  chk("rnd d_rdata", d_rdata, e_drd);
      chk("rnd if_stall", if_stall, if_req && !e_iack);
      chk("rnd d_stall", d_stall, d_req && !e_dack);
      if (e_iack) i_pend = 0;
      if (e_dack) d_pend = 0;
      if (m_busy) begin
        if (done_e) m_busy = 0;
        else m_cyc++;
      end else if (if_req || d_req) begin
        m_busy = 1; m_cyc = 1;
        if (if_req && (!d_req || m_streak >= int'(MAXS))) begin
          m_owner_d = 0; m_we = 0; m_addr = if_addr & ~32'h3; m_streak = 0;
        end else begin
          m_owner_d = 1; m_we = d_we; m_addr = d_addr & ~32'h3; m_wdata = d_wdata;
          m_streak = if_req ? m_streak + 1 : 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
